// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU sequencer for the EX stage.
// One bit per cycle, results into HI/LO; also serves MTHI/MTLO and MFHI/MFLO.
module ex_muldiv_unit #(
  parameter int BITS_SIZE = 32,
  parameter int BITS_CNT  = 6
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic [1:0]           i_md_op,
  input  logic [BITS_SIZE-1:0] i_data_a,
  input  logic [BITS_SIZE-1:0] i_data_b,
  input  logic                 i_abort,
  input  logic                 i_mthi,
  input  logic                 i_mtlo,
  output logic [BITS_SIZE-1:0] o_hi,
  output logic [BITS_SIZE-1:0] o_lo,
  output logic                 o_stall,
  output logic                 o_done
);

  localparam int W = BITS_SIZE;
  localparam logic [BITS_CNT-1:0] LAST =
    BITS_CNT'(BITS_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t              state;
  logic [BITS_CNT-1:0] cnt;
  logic [2*W-1:0]      acc;
  logic [W-1:0]        opb;
  logic                is_signed;
  logic                is_div;
  logic                sign_a;
  logic                sign_x;
  logic                b_zero;

  logic                in_sgn;
  logic                neg_a;
  logic                neg_b;
  logic [W-1:0]        mag_a;
  logic [W-1:0]        mag_b;

  logic [W:0]          sum;
  logic [W:0]          rem_sh;
  logic [W:0]          diff;
  logic                ge;
  logic [2*W-1:0]      acc_nxt;

  logic [2*W-1:0]      prod;
  logic [W-1:0]        quo;
  logic [W-1:0]        rem;
  logic [W-1:0]        res_hi;
  logic [W-1:0]        res_lo;

  assign o_stall = (state != IDLE);

  // Operand magnitudes; the most negative value maps to 2^(W-1) unsigned.
  always_comb begin
    in_sgn = ~i_md_op[0];
    neg_a  = in_sgn & i_data_a[W-1];
    neg_b  = in_sgn & i_data_b[W-1];
    mag_a  = neg_a ? -i_data_a : i_data_a;
    mag_b  = neg_b ? -i_data_b : i_data_b;
  end

  // One shift-add or restoring shift-subtract step.
  always_comb begin
    sum = {1'b0, acc[2*W-1:W]}
        + (acc[0] ? {1'b0, opb} : '0);
    rem_sh = acc[2*W-1:W-1];
    diff   = rem_sh - {1'b0, opb};
    ge     = ~diff[W];
    if (is_div)
      acc_nxt = {ge ? diff[W-1:0] : rem_sh[W-1:0],
                 acc[W-2:0], ge};
    else
      acc_nxt = {sum, acc[W-1:1]};
  end

  // Sign correction; a zero divisor leaves the dividend as remainder.
  always_comb begin
    prod = (is_signed && sign_x) ? -acc : acc;
    quo  = acc[W-1:0];
    rem  = acc[2*W-1:W];
    if (is_div) begin
      res_lo = b_zero ? '1
             : ((is_signed && sign_x) ? -quo : quo);
      res_hi = (is_signed && sign_a) ? -rem : rem;
    end else begin
      res_hi = prod[2*W-1:W];
      res_lo = prod[W-1:0];
    end
  end

  // Sequencer FSM with HI/LO and done registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      opb       <= '0;
      is_signed <= 1'b0;
      is_div    <= 1'b0;
      sign_a    <= 1'b0;
      sign_x    <= 1'b0;
      b_zero    <= 1'b0;
      o_hi      <= '0;
      o_lo      <= '0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            is_signed <= in_sgn;
            is_div    <= i_md_op[1];
            sign_a    <= neg_a;
            sign_x    <= neg_a ^ neg_b;
            b_zero    <= (i_data_b == '0);
            acc       <= {{W{1'b0}}, mag_a};
            opb       <= mag_b;
            cnt       <= '0;
            state     <= CALC;
          end else begin
            if (i_mthi) o_hi <= i_data_a;
            if (i_mtlo) o_lo <= i_data_a;
          end
        end
        CALC: begin
          if (i_abort) begin
            state <= IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + BITS_CNT'(1);
            if (cnt == LAST) state <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
          if (!i_abort) begin
            o_hi   <= res_hi;
            o_lo   <= res_lo;
            o_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed vectors for ex_muldiv_unit.
// Hand-computed HI/LO, latency and stall/done timing checks.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        abort;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;
  logic        done;

  int n_vec;
  int n_err;

  ex_muldiv_unit #(
    .BITS_SIZE(32),
    .BITS_CNT (6)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_start  (start),
    .i_md_op  (md_op),
    .i_data_a (data_a),
    .i_data_b (data_b),
    .i_abort  (abort),
    .i_mthi   (mthi),
    .i_mtlo   (mtlo),
    .o_hi     (hi),
    .o_lo     (lo),
    .o_stall  (stall),
    .o_done   (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch at edge E0, then count edges until o_done is seen.
  task automatic run_op(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output int edges);
    md_op  = op;
    data_a = a;
    data_b = b;
    start  = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    while (!done && edges < 100) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if ({hi, lo} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_hilo: got %h_%h want 0", hi, lo);
    end
    n_vec++;
    if ({stall, done} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 00",
               {stall, done});
    end
  endtask

  task automatic test_multu_max();
    int st;
    md_op  = 2'b01;
    data_a = 32'hFFFF_FFFF;
    data_b = 32'hFFFF_FFFF;
    start  = 1'b1;
    tick();
    start = 1'b0;
    st = 0;
    while (stall && st < 100) begin
      st++;
      tick();
    end
    n_vec++;
    if (st != 33) begin
      n_err++;
      $display("FAIL stall_len: got %0d want 33", st);
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL done_after_e33: got %b want 1", done);
    end
    n_vec++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin
      n_err++;
      $display("FAIL multu_max: got %h_%h want fffffffe_00000001",
               hi, lo);
    end
    tick();
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_signed();
    int e;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, e);
    n_vec++;
    if (e != 33 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      n_err++;
      $display("FAIL mult_neg: got e=%0d %h_%h want 33 ffffffff_fffffff1",
               e, hi, lo);
    end
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, e);
    n_vec++;
    if (e != 33 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_err++;
      $display("FAIL div_neg: got e=%0d %h_%h want 33 ffffffff_fffffffd",
               e, hi, lo);
    end
    run_op(2'b11, 32'd100, 32'd7, e);
    n_vec++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      n_err++;
      $display("FAIL divu: got %h_%h want 00000002_0000000e",
               hi, lo);
    end
  endtask

  task automatic test_div_edge();
    int e;
    run_op(2'b11, 32'd7, 32'd0, e);
    n_vec++;
    if (e != 33 || hi !== 32'd7 || lo !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL divu_zero: got e=%0d %h_%h want 33 00000007_ffffffff",
               e, hi, lo);
    end
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, e);
    n_vec++;
    if (hi !== 32'hFFFF_FFF9 || lo !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL div_zero_neg: got %h_%h want fffffff9_ffffffff",
               hi, lo);
    end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, e);
    n_vec++;
    if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL div_ovf: got %h_%h want 00000000_80000000",
               hi, lo);
    end
  endtask

  task automatic test_abort();
    int e;
    int seen;
    mthi   = 1'b1;
    data_a = 32'h11;
    tick();
    mthi   = 1'b0;
    mtlo   = 1'b1;
    data_a = 32'h22;
    tick();
    mtlo = 1'b0;
    n_vec++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      n_err++;
      $display("FAIL mt_preload: got %h_%h want 00000011_00000022",
               hi, lo);
    end
    md_op  = 2'b00;
    data_a = 32'd3;
    data_b = 32'd4;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: stall got %b want 0", stall);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      tick();
    end
    n_vec++;
    if (seen != 0 || hi !== 32'h11 || lo !== 32'h22) begin
      n_err++;
      $display("FAIL abort_hold: got done=%0d %h_%h want 0 00000011_00000022",
               seen, hi, lo);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_vec++;
    if (stall !== 1'b0 || hi !== 32'h11) begin
      n_err++;
      $display("FAIL abort_in_idle: got stall=%b hi=%h want 0 00000011",
               stall, hi);
    end
    md_op  = 2'b01;
    data_a = 32'd5;
    data_b = 32'd6;
    mthi   = 1'b1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    mthi  = 1'b0;
    n_vec++;
    if (stall !== 1'b1 || hi !== 32'h11) begin
      n_err++;
      $display("FAIL start_mthi: got stall=%b hi=%h want 1 00000011",
               stall, hi);
    end
    e = 0;
    while (!done && e < 100) begin
      tick();
      e++;
    end
    n_vec++;
    if (e != 33 || hi !== 32'h0 || lo !== 32'd30) begin
      n_err++;
      $display("FAIL start_mthi_res: got e=%0d %h_%h want 33 00000000_0000001e",
               e, hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    md_op  = 2'b01;
    data_a = 32'd9;
    data_b = 32'd9;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    n_vec++;
    if (stall !== 1'b1 || lo !== 32'd30) begin
      n_err++;
      $display("FAIL pre_reset: got stall=%b lo=%h want 1 0000001e",
               stall, lo);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({hi, lo} !== 64'h0 || stall !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got %h_%h s=%b d=%b want all 0",
               hi, lo, stall, done);
    end
    #2;
    rst_n = 1'b1;
    tick();
    run_op(2'b01, 32'd6, 32'd7, e);
    n_vec++;
    if (e != 33 || hi !== 32'h0 || lo !== 32'd42) begin
      n_err++;
      $display("FAIL post_reset: got e=%0d %h_%h want 33 00000000_0000002a",
               e, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    run_op(2'b01, 32'd2, 32'd2, e);
    n_vec++;
    if (e != 33 || done !== 1'b1 || lo !== 32'd4 || hi !== 32'h0) begin
      n_err++;
      $display("FAIL b2b_first: got e=%0d d=%b %h_%h want 33 1 00000000_00000004",
               e, done, hi, lo);
    end
    md_op  = 2'b01;
    data_a = 32'd3;
    data_b = 32'd4;
    start  = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if (stall !== 1'b1 || lo !== 32'd4) begin
      n_err++;
      $display("FAIL b2b_accept: got stall=%b lo=%h want 1 00000004",
               stall, lo);
    end
    e = 0;
    while (!done && e < 100) begin
      tick();
      e++;
    end
    n_vec++;
    if (e != 33 || lo !== 32'd12 || hi !== 32'h0) begin
      n_err++;
      $display("FAIL b2b_second: got e=%0d %h_%h want 33 00000000_0000000c",
               e, hi, lo);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    start  = 1'b0;
    md_op  = 2'b00;
    data_a = '0;
    data_b = '0;
    abort  = 1'b0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_multu_max();
    test_signed();
    test_div_edge();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
